drive_ctrl: RTL and testbench
=============================

# drive_ctrl

Top-level sequencing controller for the car. It owns the architectural `power`, `state` and `moving_state` registers. It turns power on and off from the debounced power buttons, from the manual-mode engine-kill request, and from an idle timeout. It also selects which driving-mode engine (manual, semi-auto, auto) supplies the next state each cycle, and closes the loop back to the combinational mode engines.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 2_000_000: cycles `power_on` must stay high to register a press (20 ms at 100 MHz).
- `HOLD_CYC`, default 100_000_000: cycles `power_off` must stay high to power down (1 s).
- `IDLE_CYC`, default 1_000_000_000: cycles idle in NSTART/NON_MOVING before auto power-off (10 s).

Ports:
- `clk` in 1: system clock. One clock domain. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `power_on` in 1: power-on button, already synchronised.
- `power_off` in 1: power-off button, already synchronised.
- `mode_sel` in 2: 00 manual, 01 semi-auto, 10 auto, 11 reserved.
- `man_next_state` in 2, `man_next_moving_state` in 4, `man_power` in 1: outputs of the manual engine.
- `semi_next_state` in 2, `semi_next_moving_state` in 4: outputs of the semi-auto engine.
- `auto_next_state` in 2, `auto_next_moving_state` in 4: outputs of the auto engine.
- `power` out 1: registered power state.
- `state` out 2: registered car state.
- `moving_state` out 4: registered moving state.
- `active_mode` out 2: latched driving mode.
- `mode_light` out 3: one-hot of `active_mode` (manual 001, semi 010, auto 100); 000 when `power`=0.

## Operation
- Reset values: `power`=0, `state`=NSTART, `moving_state`=NON_MOVING, `active_mode`=00, `mode_light`=000. All counters are 0.
- Power-on detector:
  - The counter increments while `power_on`=1 and clears when it is 0.
  - Reaching `DEBOUNCE_CYC` fires one press event, then the detector stays armed-off until `power_on` returns to 0.
  - The event sets `power`=1, `state`=NSTART, `moving_state`=NON_MOVING, and latches `active_mode`=`mode_sel` (if 11, it keeps the old value).
  - A press while `power`=1 has no effect.
- Power-off detector: the counter increments while `power_off`=1 and clears on release. Reaching `HOLD_CYC` forces `power`=0.
- Engine kill: `power`=1, `active_mode`=manual and `man_power`=0 → `power`=0 on the next edge.
- Idle timer:
  - Counts while `power`=1, `state`=NSTART and `moving_state`=NON_MOVING; clears otherwise.
  - Reaching `IDLE_CYC` forces `power`=0.
- Normal update, when `power`=1 and no event fires: `state` and `moving_state` load the `next_*` pair of the engine selected by `active_mode`.
- Mode re-latch:
  - `active_mode` follows `mode_sel` (11 ignored) only on cycles where registered `state`=NSTART.
  - In START or MOVING, `mode_sel` changes are ignored until the car returns to NSTART.
- Any power-down sets `state`=NSTART and `moving_state`=NON_MOVING and clears the idle counter. While `power`=0 these stay forced.
- Priority per edge, highest first: `rst`; off-hold expiry; engine kill; idle expiry; power-on event; normal update.
- Undefined engine codes (e.g. state 11) are loaded as-is. Legality is the engines' responsibility.

## Timing
- Every output is registered.
- The selected engine's `next_*` appears on `state`/`moving_state` one edge later.
- A power-on event updates `power` on the edge where the counter reaches `DEBOUNCE_CYC`, i.e. after `DEBOUNCE_CYC` consecutive high samples.
- Off-hold: `power` drops after `HOLD_CYC` consecutive high samples. A release on any earlier cycle restarts the count.
- Power-off with `power_off` held past expiry: `power` stays 0. The off detector does not retrigger until release.
- Simultaneous off-hold expiry and power-on event: off wins.
- `rst` mid-count clears all counters; a button still held after reset must complete a fresh count.
- Counter widths are `$clog2(N+1)`. Counters saturate and never wrap.

## Structure
- Shared package `car_pkg` holds:
  - POFF/PON, NSTART/START/MOVING;
  - NON_MOVING/MOVE_FORWARD/MOVE_BACK/TURN_LEFT/TURN_RIGHT;
  - MODE_MANUAL/MODE_SEMI/MODE_AUTO codes.
- Sub-module `hold_detect`: parameter N; ports `in` → one-cycle `fire`, re-armed by release. Instantiated twice (on: N=`DEBOUNCE_CYC`, off: N=`HOLD_CYC`).
- Idle timer and mode mux are inline.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=4, `HOLD_CYC`=8, `IDLE_CYC`=16.
1. `power_on` high 3 cycles then low → `power` stays 0. High 4 cycles → `power`=1, `state`=00, `moving_state`=0000, `mode_light`=001 (`mode_sel`=00).
2. Powered in manual with `man_next_state`=10, `man_next_moving_state`=0001 → `state`=10 and `moving_state`=0001 one edge later. Then `man_power`=0 → `power`=0, `state`=00, `moving_state`=0000 next edge.
3. `power_off` high 7 cycles, low 1, high 8 → `power` remains 1 through the first burst and drops exactly on the 8th cycle of the second burst.
4. Powered, idle in NSTART for 15 cycles, then engine reports START for 1 cycle, then idle again → no shutdown at cycle 16. `power`=0 after 16 further idle cycles.
5. In MOVING (auto mode), `mode_sel` switches to 00 → `active_mode` stays 10. Once auto engine returns NSTART, `active_mode`=00 on the following edge. `mode_sel`=11 → no change.
6. `power_off` hold expiry coinciding with a power-on event, and `rst` asserted mid-debounce → `power`=0 in both cases; after `rst`, all outputs are at reset values and a full `DEBOUNCE_CYC` is required.

Source files
------------

// File: rtl/car_pkg.sv
//------------------------------------------------------------------------------
// car_pkg : shared power, car-state, moving-state and driving-mode codes.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package car_pkg;

   localparam logic       POFF = 1'b0;
   localparam logic       PON  = 1'b1;

   localparam logic [1:0] NSTART = 2'b00;
   localparam logic [1:0] START  = 2'b01;
   localparam logic [1:0] MOVING = 2'b10;

   localparam logic [3:0] NON_MOVING   = 4'b0000;
   localparam logic [3:0] MOVE_FORWARD = 4'b0001;
   localparam logic [3:0] MOVE_BACK    = 4'b0010;
   localparam logic [3:0] TURN_LEFT    = 4'b0100;
   localparam logic [3:0] TURN_RIGHT   = 4'b1000;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_SEMI   = 2'b01;
   localparam logic [1:0] MODE_AUTO   = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
      logic [2:0] light;
      light = 3'b000;
      case (mode)
         MODE_MANUAL: light = 3'b001;
         MODE_SEMI:   light = 3'b010;
         MODE_AUTO:   light = 3'b100;
         default:     light = 3'b000;
      endcase
      return light;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hold_detect.sv
//------------------------------------------------------------------------------
// hold_detect : one-cycle fire after N consecutive high samples; re-armed by release.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hold_detect #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic fire
);

   localparam int CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] r_cnt;

   // Saturating at N keeps fire from repeating until the input drops.
   assign fire = in && (r_cnt == CNT_W'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!in) begin
         r_cnt <= '0;
      end else if (r_cnt != CNT_W'(N)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/drive_ctrl.sv
//------------------------------------------------------------------------------
// drive_ctrl : power sequencing, idle shutdown and driving-mode engine selection.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module drive_ctrl
   import car_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 2_000_000,
   parameter int HOLD_CYC     = 100_000_000,
   parameter int IDLE_CYC     = 1_000_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       power_on,
   input  logic       power_off,
   input  logic [1:0] mode_sel,
   input  logic [1:0] man_next_state,
   input  logic [3:0] man_next_moving_state,
   input  logic       man_power,
   input  logic [1:0] semi_next_state,
   input  logic [3:0] semi_next_moving_state,
   input  logic [1:0] auto_next_state,
   input  logic [3:0] auto_next_moving_state,
   output logic       power,
   output logic [1:0] state,
   output logic [3:0] moving_state,
   output logic [1:0] active_mode,
   output logic [2:0] mode_light
);

   localparam int IDLE_W = $clog2(IDLE_CYC + 1);

   logic              r_power;
   logic [1:0]        r_state;
   logic [3:0]        r_moving_state;
   logic [1:0]        r_active_mode;
   logic [2:0]        r_mode_light;
   logic [IDLE_W-1:0] r_idle_cnt;

   logic              w_on_fire;
   logic              w_off_fire;
   logic [1:0]        w_sel_state;
   logic [3:0]        w_sel_moving;
   logic              w_idle_cond;
   logic              w_idle_fire;
   logic              w_kill;
   logic              w_power_down;
   logic              w_pon_event;
   logic              w_next_power;
   logic [1:0]        w_next_state;
   logic [3:0]        w_next_moving;
   logic [1:0]        w_next_mode;
   logic [IDLE_W-1:0] w_next_idle;

   hold_detect #(.N(DEBOUNCE_CYC)) u_on_detect (
      .clk  (clk),
      .rst  (rst),
      .in   (power_on),
      .fire (w_on_fire)
   );

   hold_detect #(.N(HOLD_CYC)) u_off_detect (
      .clk  (clk),
      .rst  (rst),
      .in   (power_off),
      .fire (w_off_fire)
   );

   always_comb begin
      w_sel_state  = man_next_state;
      w_sel_moving = man_next_moving_state;
      case (r_active_mode)
         MODE_SEMI: begin
            w_sel_state  = semi_next_state;
            w_sel_moving = semi_next_moving_state;
         end
         MODE_AUTO: begin
            w_sel_state  = auto_next_state;
            w_sel_moving = auto_next_moving_state;
         end
         default: ;
      endcase

      w_idle_cond  = r_power && (r_state == NSTART) && (r_moving_state == NON_MOVING);
      w_idle_fire  = w_idle_cond && (r_idle_cnt == IDLE_W'(IDLE_CYC - 1));
      w_kill       = r_power && (r_active_mode == MODE_MANUAL) && !man_power;
      w_power_down = w_off_fire || w_kill || w_idle_fire;
      w_pon_event  = !r_power && w_on_fire && !w_off_fire;

      // Unpowered and power-down cycles pin the car at NSTART / NON_MOVING.
      w_next_power  = r_power;
      w_next_state  = NSTART;
      w_next_moving = NON_MOVING;
      if (w_power_down) begin
         w_next_power = POFF;
      end else if (!r_power) begin
         if (w_pon_event) w_next_power = PON;
      end else begin
         w_next_state  = w_sel_state;
         w_next_moving = w_sel_moving;
      end

      w_next_mode = r_active_mode;
      if ((mode_sel != MODE_RSVD) && (w_pon_event || (r_power && (r_state == NSTART))))
         w_next_mode = mode_sel;

      w_next_idle = '0;
      if (w_idle_cond && !w_power_down)
         w_next_idle = (r_idle_cnt == IDLE_W'(IDLE_CYC)) ? r_idle_cnt : r_idle_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_power        <= POFF;
         r_state        <= NSTART;
         r_moving_state <= NON_MOVING;
         r_active_mode  <= MODE_MANUAL;
         r_mode_light   <= 3'b000;
         r_idle_cnt     <= '0;
      end else begin
         r_power        <= w_next_power;
         r_state        <= w_next_state;
         r_moving_state <= w_next_moving;
         r_active_mode  <= w_next_mode;
         r_mode_light   <= w_next_power ? mode_onehot(w_next_mode) : 3'b000;
         r_idle_cnt     <= w_next_idle;
      end
   end

   assign power        = r_power;
   assign state        = r_state;
   assign moving_state = r_moving_state;
   assign active_mode  = r_active_mode;
   assign mode_light   = r_mode_light;

endmodule

`default_nettype wire

// File: tb/tb_drive_ctrl.sv
//------------------------------------------------------------------------------
// tb_drive_ctrl : directed scenarios plus randomized run against a run-length model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_drive_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 8;
   localparam int IDLE = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       power_on = 1'b0;
   logic       power_off = 1'b0;
   logic [1:0] mode_sel = 2'b00;
   logic [1:0] man_next_state = 2'b00;
   logic [3:0] man_next_moving_state = 4'b0000;
   logic       man_power = 1'b1;
   logic [1:0] semi_next_state = 2'b00;
   logic [3:0] semi_next_moving_state = 4'b0000;
   logic [1:0] auto_next_state = 2'b00;
   logic [3:0] auto_next_moving_state = 4'b0000;
   logic       power;
   logic [1:0] state;
   logic [3:0] moving_state;
   logic [1:0] active_mode;
   logic [2:0] mode_light;

   int checks = 0;
   int errors = 0;

   drive_ctrl #(.DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .IDLE_CYC(IDLE)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .power_on               (power_on),
      .power_off              (power_off),
      .mode_sel               (mode_sel),
      .man_next_state         (man_next_state),
      .man_next_moving_state  (man_next_moving_state),
      .man_power              (man_power),
      .semi_next_state        (semi_next_state),
      .semi_next_moving_state (semi_next_moving_state),
      .auto_next_state        (auto_next_state),
      .auto_next_moving_state (auto_next_moving_state),
      .power                  (power),
      .state                  (state),
      .moving_state           (moving_state),
      .active_mode            (active_mode),
      .mode_light             (mode_light)
   );

   always #5 clk = ~clk;

   // Reference model: button activity tracked as consecutive-high run lengths.
   logic       m_power = 1'b0;
   logic [1:0] m_state = 2'b00;
   logic [3:0] m_mov   = 4'b0000;
   logic [1:0] m_mode  = 2'b00;
   int         on_run = 0, off_run = 0, idle_run = 0;

   task automatic model_step();
      bit on_e, off_e, kill, idle_e, relatch;
      logic [1:0] nxt_s;
      logic [3:0] nxt_m;
      if (rst) begin
         m_power = 1'b0; m_state = 2'b00; m_mov = 4'b0000; m_mode = 2'b00;
         on_run = 0; off_run = 0; idle_run = 0;
         return;
      end
      on_run   = power_on  ? on_run + 1  : 0;
      off_run  = power_off ? off_run + 1 : 0;
      idle_run = (m_power && m_state == 2'b00 && m_mov == 4'b0000) ? idle_run + 1 : 0;
      on_e   = (on_run == DEB);
      off_e  = (off_run == HOLD);
      idle_e = (idle_run == IDLE);
      kill   = m_power && (m_mode == 2'b00) && !man_power;
      relatch = (mode_sel != 2'b11) &&
                ((m_power && m_state == 2'b00) || (!m_power && on_e && !off_e));
      if (m_mode == 2'b01)      begin nxt_s = semi_next_state; nxt_m = semi_next_moving_state; end
      else if (m_mode == 2'b10) begin nxt_s = auto_next_state; nxt_m = auto_next_moving_state; end
      else                      begin nxt_s = man_next_state;  nxt_m = man_next_moving_state;  end
      if (off_e || kill || idle_e) begin
         m_power = 1'b0; m_state = 2'b00; m_mov = 4'b0000; idle_run = 0;
      end else if (!m_power) begin
         if (on_e) m_power = 1'b1;
         m_state = 2'b00; m_mov = 4'b0000;
      end else begin
         m_state = nxt_s; m_mov = nxt_m;
      end
      if (relatch) m_mode = mode_sel;
   endtask

   function automatic logic [11:0] exp_vec();
      logic [2:0] light;
      light = m_power ? (3'b001 << m_mode) : 3'b000;
      return {m_power, m_state, m_mov, m_mode, light};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {power, state, moving_state, active_mode, mode_light};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic power_up();
      power_on = 1'b1;
      repeat (DEB) tick();
      power_on = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      checks++;
      if (dut_vec() !== 12'h000) begin
         errors++;
         $display("FAIL reset_state got %h want %h", dut_vec(), 12'h000);
      end
   endtask

   task automatic test_debounce();
      power_on = 1'b1;
      repeat (3) tick();
      power_on = 1'b0;
      tick();
      checks++;
      if (power !== 1'b0) begin
         errors++;
         $display("FAIL short_press got power=%b want 0", power);
      end
      power_on = 1'b1;
      repeat (4) tick();
      power_on = 1'b0;
      checks++;
      if ({power, state, moving_state, mode_light} !== {1'b1, 2'b00, 4'b0000, 3'b001}) begin
         errors++;
         $display("FAIL full_press got %b want %b",
                  {power, state, moving_state, mode_light}, {1'b1, 2'b00, 4'b0000, 3'b001});
      end
   endtask

   task automatic test_manual_kill();
      man_next_state = 2'b10; man_next_moving_state = 4'b0001;
      tick();
      checks++;
      if ({state, moving_state} !== {2'b10, 4'b0001}) begin
         errors++;
         $display("FAIL manual_load got %b want %b", {state, moving_state}, {2'b10, 4'b0001});
      end
      man_power = 1'b0;
      tick();
      man_power = 1'b1;
      checks++;
      if ({power, state, moving_state} !== {1'b0, 2'b00, 4'b0000}) begin
         errors++;
         $display("FAIL engine_kill got %b want %b", {power, state, moving_state}, 7'b0);
      end
   endtask

   task automatic test_off_hold();
      power_up();
      power_off = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (power !== 1'b1) begin
            errors++;
            $display("FAIL off_burst1 cycle %0d got power=%b want 1", i + 1, power);
         end
      end
      power_off = 1'b0;
      tick();
      power_off = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++;
         if (power !== (i < 8 ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL off_burst2 cycle %0d got power=%b want %b", i, power, i < 8);
         end
      end
      power_off = 1'b0;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL off_model got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_idle();
      man_next_state = 2'b00; man_next_moving_state = 4'b0000;
      power_up();
      repeat (14) tick();
      man_next_state = 2'b01;
      tick();
      man_next_state = 2'b00;
      tick();
      checks++;
      if ({power, state} !== {1'b1, 2'b00}) begin
         errors++;
         $display("FAIL idle_interrupt got %b want %b", {power, state}, 3'b100);
      end
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if (power !== (i < 16 ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL idle_timeout cycle %0d got power=%b want %b", i, power, i < 16);
         end
      end
   endtask

   task automatic test_mode_relatch();
      mode_sel = 2'b10;
      auto_next_state = 2'b00; auto_next_moving_state = 4'b0000;
      power_up();
      auto_next_state = 2'b10; auto_next_moving_state = 4'b0001;
      tick();
      mode_sel = 2'b00;
      repeat (3) tick();
      checks++;
      if ({state, active_mode, mode_light} !== {2'b10, 2'b10, 3'b100}) begin
         errors++;
         $display("FAIL mode_locked got %b want %b", {state, active_mode, mode_light}, 7'b1010100);
      end
      auto_next_state = 2'b00; auto_next_moving_state = 4'b0000;
      tick();
      checks++;
      if ({state, active_mode} !== {2'b00, 2'b10}) begin
         errors++;
         $display("FAIL mode_hold_edge got %b want %b", {state, active_mode}, 4'b0010);
      end
      tick();
      checks++;
      if ({active_mode, mode_light} !== {2'b00, 3'b001}) begin
         errors++;
         $display("FAIL mode_relatch got %b want %b", {active_mode, mode_light}, 5'b00001);
      end
      mode_sel = 2'b11;
      tick();
      checks++;
      if (active_mode !== 2'b00) begin
         errors++;
         $display("FAIL mode_reserved got %b want 00", active_mode);
      end
      mode_sel = 2'b01;
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || active_mode !== 2'b01) begin
         errors++;
         $display("FAIL mode_semi got %h want %h", dut_vec(), exp_vec());
      end
      mode_sel = 2'b00;
   endtask

   task automatic test_collision();
      rst = 1'b1; tick(); rst = 1'b0;
      power_off = 1'b1;
      repeat (4) tick();
      power_on = 1'b1;
      repeat (4) tick();
      checks++;
      if (power !== 1'b0) begin
         errors++;
         $display("FAIL off_beats_on got power=%b want 0", power);
      end
      power_on = 1'b0; power_off = 1'b0;
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || power !== 1'b0) begin
         errors++;
         $display("FAIL collision_after got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      man_next_state = 2'b10; man_next_moving_state = 4'b0010;
      power_up();
      tick();
      power_on = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (dut_vec() !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid got %h want %h", dut_vec(), 12'h000);
      end
      repeat (3) tick();
      checks++;
      if (power !== 1'b0) begin
         errors++;
         $display("FAIL reset_recount_early got power=%b want 0", power);
      end
      tick();
      checks++;
      if (power !== 1'b1) begin
         errors++;
         $display("FAIL reset_recount_full got power=%b want 1", power);
      end
      power_on = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0)  power_on  = ~power_on;
         if ($urandom_range(0, 9) == 0)  power_off = ~power_off;
         if ($urandom_range(0, 7) == 0)  mode_sel  = 2'($urandom_range(0, 3));
         man_power              = ($urandom_range(0, 19) != 0);
         rst                    = ($urandom_range(0, 199) == 0);
         man_next_state         = 2'($urandom_range(0, 3));
         man_next_moving_state  = 4'($urandom);
         semi_next_state        = 2'($urandom_range(0, 3));
         semi_next_moving_state = 4'($urandom);
         auto_next_state        = 2'($urandom_range(0, 3));
         auto_next_moving_state = 4'($urandom);
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cycle %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_manual_kill();
      test_off_hold();
      test_idle();
      test_mode_relatch();
      test_collision();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
